niosii_top_onchip_mem_tester: RTL and testbench
===============================================

NIOSII_TOP_ONCHIP_MEM_TESTER -- requirements
Module: niosii_top_onchip_mem_tester

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the target memory slave.
REQ-002 SHALL have parameter READ_LATENCY, default 1, fixed cycles from read address to valid readdata.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a write-then-verify pass.
REQ-006 SHALL have port base_addr  in  ADDR_W  first word address of the pass.
REQ-007 SHALL have port length  in  ADDR_W+1  number of words, 0..2^ADDR_W.
REQ-008 SHALL have port seed  in  32  pattern seed.
REQ-009 SHALL have ports address (out, ADDR_W), byteenable (out, 4), chipselect (out, 1), write (out, 1), writedata (out, 32), readdata (in, 32): Avalon-MM master, no waitrequest.
REQ-010 SHALL have ports busy (out, 1), done (out, 1), error (out, 1), err_count (out, ADDR_W+1), err_addr (out, ADDR_W).

Function
REQ-011 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-012 IDLE: start=1 latches base_addr, length, seed, clears error/err_count/err_addr; goes to WRITE if length>0, else to DONE.
REQ-013 start SHALL be ignored in any state other than IDLE.
REQ-014 Pattern for offset i: seed + i, modulo 2^32.
REQ-015 WRITE: one word per cycle; chipselect=1, write=1, byteenable=4'hF, address=(base_addr+i) mod 2^ADDR_W, writedata=pattern(i); after word length-1, goes to READ.
REQ-016 READ: one read per cycle; chipselect=1, write=0, byteenable=4'hF, same address sequence; after word length-1, goes to DRAIN.
REQ-017 Expected data and address SHALL be pipelined READ_LATENCY cycles; readdata compared in the cycle it becomes valid.
REQ-018 DRAIN: chipselect=0; SHALL stay exactly READ_LATENCY cycles, collecting outstanding compares, then go to DONE.
REQ-019 Mismatch: error set (sticky until next accepted start), err_count incremented, saturating at 2^(ADDR_W+1)-1.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE.
REQ-021 busy=1 in WRITE, READ, DRAIN, DONE; 0 in IDLE.
REQ-022 Address wrap: base_addr+i beyond 2^ADDR_W-1 SHALL wrap to 0.
REQ-023 In IDLE, DRAIN, DONE: chipselect=0, write=0; address/writedata hold last values.
REQ-024 Full pass latency: start to done = 1 + 2*length + READ_LATENCY cycles for length>0; 1 cycle for length=0.

Reset
REQ-025 reset=1 SHALL asynchronously force IDLE and all outputs to 0, including mid-pass (chipselect/write drop without waiting for clk).
REQ-026 Compares in flight at reset SHALL be discarded; no error update after reset deasserts.

Configuration
REQ-027 Macro MEM_TESTER_ERR_CAPTURE_EN, when defined, SHALL make err_addr hold the address of the first mismatch of the pass.
REQ-028 Without MEM_TESTER_ERR_CAPTURE_EN, err_addr SHALL be constant 0 and no capture register SHALL be built; error/err_count unaffected.

Verification
REQ-029 base_addr=0x010, length=4, seed=0xA5A5_0000, ideal RAM -> writes 0xA5A50000..0xA5A50003 at 0x010..0x013, reads same, done at cycle 10 after start, error=0.
REQ-030 base_addr=0x3FE, length=4 -> addresses 0x3FE,0x3FF,0x000,0x001 in both phases.
REQ-031 RAM model corrupts word 0x012 (bit 0 flip), base 0x010, length 4 -> error=1, err_count=1, err_addr=0x012 with macro, 0 without.
REQ-032 length=0 -> no chipselect, busy high one cycle, done pulse next cycle, error=0.
REQ-033 reset asserted mid-READ of length=8 pass -> chipselect=0 immediately, busy=0, err_count=0; fresh start afterwards completes with error=0.
REQ-034 start pulsed again during WRITE -> ignored; pass completes with original parameters, single done pulse.

Source files
------------

// File: rtl/niosii_top_onchip_mem_tester.sv
// Write-then-verify tester for an Avalon-MM on-chip memory slave (no waitrequest).
// Optional first-mismatch address capture: define MEM_TESTER_ERR_CAPTURE_EN.
module niosii_top_onchip_mem_tester #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] DRAIN_LAST = (ADDR_W+1)'(READ_LATENCY-1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base_q, addr_q;
  logic [ADDR_W:0]     last_q, idx;
  logic [31:0]         seed_q, wdata_q, exp_q;
  logic                accept, last_word, drain_last, mismatch;

  logic [READ_LATENCY-1:0]        vld_pipe;
  logic [READ_LATENCY-1:0][31:0]  exp_pipe;

  assign accept     = (state == IDLE) && start;
  assign last_word  = (idx == last_q);
  assign drain_last = (idx == DRAIN_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length != '0) ? WRITE : DONE;
      WRITE:   if (last_word) state_nxt = READ;
      READ:    if (last_word) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data registers double as the bus outputs, so they hold between phases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      last_q  <= '0;
      seed_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      exp_q   <= '0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          base_q  <= base_addr;
          last_q  <= length - (ADDR_W+1)'(1);
          seed_q  <= seed;
          addr_q  <= base_addr;
          wdata_q <= seed;
          idx     <= '0;
        end
        WRITE: if (last_word) begin
          idx    <= '0;
          addr_q <= base_q;
          exp_q  <= seed_q;
        end else begin
          idx     <= idx + (ADDR_W+1)'(1);
          addr_q  <= addr_q + ADDR_W'(1);
          wdata_q <= wdata_q + 32'd1;
        end
        READ: if (last_word) begin
          idx <= '0;
        end else begin
          idx    <= idx + (ADDR_W+1)'(1);
          addr_q <= addr_q + ADDR_W'(1);
          exp_q  <= exp_q + 32'd1;
        end
        DRAIN:   idx <= idx + (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Expected data rides alongside each read until its readdata arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
    end else begin
      vld_pipe[0] <= (state == READ);
      exp_pipe[0] <= exp_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        exp_pipe[k] <= exp_pipe[k-1];
      end
    end
  end

  assign mismatch = vld_pipe[READ_LATENCY-1] && (readdata != exp_pipe[READ_LATENCY-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (accept) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (mismatch) begin
      error <= 1'b1;
      if (err_count != '1) err_count <= err_count + (ADDR_W+1)'(1);
    end
  end

`ifdef MEM_TESTER_ERR_CAPTURE_EN
  logic [READ_LATENCY-1:0][ADDR_W-1:0] addr_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_pipe <= '0;
    end else begin
      addr_pipe[0] <= addr_q;
      for (int k = 1; k < READ_LATENCY; k++) addr_pipe[k] <= addr_pipe[k-1];
    end
  end

  // Only the first mismatch of a pass is kept (error still clear at that point).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    err_addr <= '0;
    else if (accept)              err_addr <= '0;
    else if (mismatch && !error)  err_addr <= addr_pipe[READ_LATENCY-1];
  end
`else
  assign err_addr = '0;
`endif

  assign chipselect = (state == WRITE) || (state == READ);
  assign write      = (state == WRITE);
  assign byteenable = chipselect ? 4'hF : 4'h0;
  assign address    = addr_q;
  assign writedata  = wdata_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_niosii_top_onchip_mem_tester.sv
// Directed bench for the on-chip memory tester with a 1-cycle-latency RAM model.
module tb_niosii_top_onchip_mem_tester;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic [31:0] seed = '0;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect, write;
  logic [31:0] writedata;
  logic [31:0] readdata = '0;
  logic        busy, done, error;
  logic [10:0] err_count;
  logic [9:0]  err_addr;

  niosii_top_onchip_mem_tester #(.ADDR_W(10), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .seed(seed), .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(readdata), .busy(busy), .done(done),
    .error(error), .err_count(err_count), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  bit          corrupt = 1'b0;

  // RAM with one-cycle read latency; optionally flips bit 0 of word 0x012 on read.
  always @(posedge clk) begin
    if (chipselect && write) mem[address] <= writedata;
    if (chipselect && !write)
      readdata <= mem[address] ^ ((corrupt && address == 10'h012) ? 32'd1 : 32'd0);
  end

  int checks = 0;
  int failures = 0;
  logic [9:0] wr_a[$];
  logic [9:0] rd_a[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_ea(input logic [31:0] a);
`ifdef MEM_TESTER_ERR_CAPTURE_EN
    return a;
`else
    return 32'd0 & a;
`endif
  endfunction

  task automatic run_pass(input logic [9:0] b, input logic [10:0] n, input logic [31:0] s,
                          input bit restart, input logic [31:0] e_err,
                          input logic [31:0] e_cnt, input logic [31:0] e_ea);
    int cyc, nw, nr;
    bit seen;
    wr_a.delete();
    rd_a.delete();
    @(negedge clk);
    base_addr = b; length = n; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; nw = 0; nr = 0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (chipselect && write) begin
          chk("wr_addr", address, (b + nw) & 32'h3FF);
          chk("wr_data", writedata, s + nw);
          wr_a.push_back(address);
          nw++;
        end else if (chipselect) begin
          chk("rd_addr", address, (b + nr) & 32'h3FF);
          rd_a.push_back(address);
          nr++;
        end
        if (restart && cyc == 2) begin
          start = 1'b1; base_addr = 10'h200; length = 11'd1; seed = 32'h0;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_latency", cyc, (n == 0) ? 32'd1 : 2 * n + 2);
    chk("wr_count", nw, n);
    chk("rd_count", nr, n);
    chk("busy_in_done", busy, 1);
    chk("error", error, e_err);
    chk("err_count", err_count, e_cnt);
    chk("err_addr", err_addr, e_ea);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #1;
    chk("rst_cs", chipselect, 0);
    chk("rst_write", write, 0);
    chk("rst_be", byteenable, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_erraddr", err_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic pass on an ideal RAM
    run_pass(10'h010, 11'd4, 32'hA5A5_0000, 1'b0, 0, 0, 0);
    chk("mem_010", mem[10'h010], 32'hA5A5_0000);
    chk("mem_011", mem[10'h011], 32'hA5A5_0001);
    chk("mem_012", mem[10'h012], 32'hA5A5_0002);
    chk("mem_013", mem[10'h013], 32'hA5A5_0003);

    // Address wrap at the top of the window
    run_pass(10'h3FE, 11'd4, 32'h1234_0000, 1'b0, 0, 0, 0);
    chk("wrap_w0", wr_a[0], 10'h3FE);
    chk("wrap_w1", wr_a[1], 10'h3FF);
    chk("wrap_w2", wr_a[2], 10'h000);
    chk("wrap_w3", wr_a[3], 10'h001);
    chk("wrap_r0", rd_a[0], 10'h3FE);
    chk("wrap_r1", rd_a[1], 10'h3FF);
    chk("wrap_r2", rd_a[2], 10'h000);
    chk("wrap_r3", rd_a[3], 10'h001);

    // Single corrupted word
    corrupt = 1'b1;
    run_pass(10'h010, 11'd4, 32'hA5A5_0000, 1'b0, 1, 1, exp_ea(32'h012));
    corrupt = 1'b0;

    // Zero length: straight to DONE, also clears the previous error
    run_pass(10'h000, 11'd0, 32'h0, 1'b0, 0, 0, 0);

    // start during WRITE is ignored
    run_pass(10'h100, 11'd4, 32'hDEAD_BEEF, 1'b1, 0, 0, 0);

    // Full-size pass
    run_pass(10'h000, 11'd1024, 32'hFFFF_FF00, 1'b0, 0, 0, 0);

    // Reset mid-READ with a corrupted compare in flight
    corrupt = 1'b1;
    @(negedge clk);
    base_addr = 10'h010; length = 11'd8; seed = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("midread_cs", chipselect, 1);
    chk("midread_wr", write, 0);
    reset = 1'b1;
    #1;
    chk("rstmid_cs", chipselect, 0);
    chk("rstmid_write", write, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_errcnt", err_count, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("postrst_error", error, 0);
    chk("postrst_errcnt", err_count, 0);
    chk("postrst_busy", busy, 0);
    corrupt = 1'b0;
    run_pass(10'h010, 11'd8, 32'h0000_0055, 1'b0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
